// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: controller states, special
// opcodes and the drain length used before the pipeline is declared halted.
package pipeline_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_DUMP   = 3'd5
    } state_t;

    localparam logic [5:0] HALT_OP_DEF  = 6'b111111;
    localparam logic [5:0] NOP_OP       = 6'b000000;
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    // RUN and STEP are the only states in which the PC and all stages move.
    function automatic logic is_advancing(input state_t s);
        return (s == S_RUN) || (s == S_STEP);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard decode: load-use interlock and branch/jump flush request.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         ex_MemRead,
    input  logic [W-1:0] ex_rt,
    input  logic [W-1:0] id_rs,
    input  logic [W-1:0] id_rt,
    input  logic         id_uses_rt,
    input  logic         mem_pc_src,
    output logic         load_use,
    output logic         branch_flush
);

    // A load into $0 never creates a dependency; rt only matters if ID reads it.
    assign load_use = ex_MemRead
                    & (ex_rt != {W{1'b0}})
                    & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign branch_flush = mem_pc_src;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: stall/flush generation, debug run/step/halt FSM
// and register-file port-1 arbitration for debug register dumps.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int         W       = 5,
    parameter int         B       = 32,
    parameter int         NREGS   = 32,
    parameter logic [5:0] HALT_OP = HALT_OP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run_req,
    input  logic         step_req,
    input  logic         stop_req,
    input  logic         dump_req,
    input  logic [5:0]   id_opcode,
    input  logic [W-1:0] id_rs,
    input  logic [W-1:0] id_rt,
    input  logic         id_uses_rt,
    input  logic [W-1:0] ex_rt,
    input  logic         ex_MemRead,
    input  logic         mem_pc_src,
    output logic         pc_en,
    output logic         if_id_en,
    output logic         if_id_flush,
    output logic         id_ex_flush,
    output logic         ex_mem_flush,
    output logic         stage_en,
    output logic         wb_en,
    output logic         rf_dbg_sel,
    output logic [W-1:0] dbg_rd_addr,
    output logic         dbg_rd_valid,
    output logic         dbg_dump_done,
    output logic         step_done,
    output logic         halted,
    output logic [B-1:0] cycle_count
);

    localparam int            CW      = $clog2(NREGS + 1);
    localparam logic [CW-1:0] NREGS_C = CW'(NREGS);
    localparam logic [B-1:0]  CNT_ONE = {{(B-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [CW-1:0] dump_q, dump_d;
    logic [1:0]    drain_q, drain_d;
    logic          halted_q, halted_d;
    logic [B-1:0]  cycle_q, cycle_d;

    logic load_use;
    logic branch_flush;
    logic halt_hit;

    hazard_detect #(.W(W)) u_hazard (
        .ex_MemRead   (ex_MemRead),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .mem_pc_src   (mem_pc_src),
        .load_use     (load_use),
        .branch_flush (branch_flush)
    );

    // State, counters and sticky halt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dump_q   <= {CW{1'b0}};
            drain_q  <= 2'd0;
            halted_q <= 1'b0;
            cycle_q  <= {B{1'b0}};
        end else begin
            state_q  <= state_d;
            dump_q   <= dump_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
            cycle_q  <= cycle_d;
        end
    end

    // Next state and pipeline control; frozen states leave every enable low.
    always_comb begin
        state_d       = state_q;
        dump_d        = dump_q;
        drain_d       = drain_q;
        halted_d      = halted_q;
        cycle_d       = cycle_q;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        stage_en      = 1'b0;
        wb_en         = 1'b0;
        rf_dbg_sel    = 1'b0;
        dbg_rd_addr   = {W{1'b0}};
        dbg_rd_valid  = 1'b0;
        dbg_dump_done = 1'b0;
        step_done     = 1'b0;
        halt_hit      = 1'b0;

        if (is_advancing(state_q)) begin
            cycle_d  = cycle_q + CNT_ONE;
            stage_en = 1'b1;
            wb_en    = 1'b1;
            // A resolved branch squashes the younger instructions, so any
            // load-use hazard among them is moot.
            if (branch_flush) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
            halt_hit = (id_opcode == HALT_OP) & ~branch_flush & ~load_use;
        end else begin
            cycle_d = cycle_q;
        end

        case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    state_d = S_DUMP;
                    dump_d  = {CW{1'b0}};
                end else if (step_req) begin
                    state_d = S_STEP;
                end else if (run_req) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (halt_hit) begin
                    state_d = S_DRAIN;
                    drain_d = 2'd0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (halt_hit) begin
                    state_d = S_DRAIN;
                    drain_d = 2'd0;
                end else begin
                    state_d   = S_IDLE;
                    step_done = 1'b1;
                end
            end
            S_DRAIN: begin
                stage_en = 1'b1;
                wb_en    = 1'b1;
                if (branch_flush) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = S_RUN;
                end else begin
                    if_id_flush = 1'b1;
                    if (drain_q == (DRAIN_CYCLES - 2'd1)) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                        drain_d  = 2'd0;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
            end
            S_HALTED: begin
                if (dump_req) begin
                    state_d = S_DUMP;
                    dump_d  = {CW{1'b0}};
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_DUMP: begin
                if (dump_q < NREGS_C) begin
                    rf_dbg_sel   = 1'b1;
                    dbg_rd_valid = 1'b1;
                    dbg_rd_addr  = dump_q[W-1:0];
                    dump_d       = dump_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    dbg_dump_done = 1'b1;
                    dump_d        = {CW{1'b0}};
                    state_d       = halted_q ? S_HALTED : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign halted      = halted_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: hazard vector table, hand-written
// step/halt/dump/reset sequences and a randomized run against a reference model.
module tb_pipeline_sequencer;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req, step_req, stop_req, dump_req;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_MemRead, mem_pc_src;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic        stage_en, wb_en, rf_dbg_sel, dbg_rd_valid, dbg_dump_done;
    logic        step_done, halted;
    logic [4:0]  dbg_rd_addr;
    logic [31:0] cycle_count;
    logic [11:0] ov;

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4, M_DUMP = 5;
    int          m_mode, m_drain, m_dump;
    logic        m_halted, m_hit;
    logic [31:0] m_count;
    logic [11:0] e_out;
    logic [4:0]  e_addr;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] ert, rs, rt;
        logic       ur, br;
        logic [4:0] exp; // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
    } vec_t;
    vec_t tbl[8];

    pipeline_sequencer dut (
        .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
        .stop_req(stop_req), .dump_req(dump_req), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rt(ex_rt),
        .ex_MemRead(ex_MemRead), .mem_pc_src(mem_pc_src), .pc_en(pc_en),
        .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .stage_en(stage_en), .wb_en(wb_en),
        .rf_dbg_sel(rf_dbg_sel), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_valid(dbg_rd_valid),
        .dbg_dump_done(dbg_dump_done), .step_done(step_done), .halted(halted),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign ov = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, stage_en,
                 wb_en, rf_dbg_sel, dbg_rd_valid, dbg_dump_done, step_done, halted};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cyc(input string nm, input logic [11:0] exp);
        @(negedge clk);
        chk(nm, 32'(ov), 32'(exp));
        tick();
    endtask

    task automatic clear_inputs();
        run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0; dump_req = 1'b0;
        id_opcode = NOP_OP; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_MemRead = 1'b0; mem_pc_src = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_mode = M_IDLE; m_drain = 0; m_dump = 0; m_halted = 1'b0; m_count = 32'd0;
    endtask

    // Expected outputs from the behavioural rules for the current mode and inputs.
    task automatic model_outputs();
        logic lu;
        lu = ex_MemRead && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        e_out = 12'd0;
        e_addr = 5'd0;
        e_out[0] = m_halted;
        m_hit = 1'b0;
        if (m_mode == M_RUN || m_mode == M_STEP) begin
            e_out[6] = 1'b1;
            e_out[5] = 1'b1;
            if (mem_pc_src) e_out[11:7] = 5'b11111;
            else if (lu)    e_out[11:7] = 5'b00010;
            else            e_out[11:7] = 5'b11000;
            m_hit = (id_opcode == HALT_OP_DEF) && !mem_pc_src && !lu;
            if (m_mode == M_STEP && !m_hit) e_out[1] = 1'b1;
        end else if (m_mode == M_DRAIN) begin
            e_out[6] = 1'b1;
            e_out[5] = 1'b1;
            e_out[11:7] = mem_pc_src ? 5'b11111 : 5'b00100;
        end else if (m_mode == M_DUMP) begin
            if (m_dump < 32) begin
                e_out[4] = 1'b1;
                e_out[3] = 1'b1;
                e_addr = 5'(m_dump);
            end else begin
                e_out[2] = 1'b1;
            end
        end
    endtask

    task automatic model_advance();
        case (m_mode)
            M_IDLE: begin
                if (dump_req) begin m_mode = M_DUMP; m_dump = 0; end
                else if (step_req) m_mode = M_STEP;
                else if (run_req) m_mode = M_RUN;
            end
            M_RUN: begin
                m_count = m_count + 32'd1;
                if (stop_req) m_mode = M_IDLE;
                else if (m_hit) begin m_mode = M_DRAIN; m_drain = 3; end
            end
            M_STEP: begin
                m_count = m_count + 32'd1;
                if (m_hit) begin m_mode = M_DRAIN; m_drain = 3; end
                else m_mode = M_IDLE;
            end
            M_DRAIN: begin
                if (mem_pc_src) m_mode = M_RUN;
                else begin
                    m_drain = m_drain - 1;
                    if (m_drain == 0) begin m_mode = M_HALTED; m_halted = 1'b1; end
                end
            end
            M_HALTED: if (dump_req) begin m_mode = M_DUMP; m_dump = 0; end
            M_DUMP: begin
                if (m_dump == 32) m_mode = m_halted ? M_HALTED : M_IDLE;
                else m_dump = m_dump + 1;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sd_cnt;
        tbl[0] = '{"no_hazard",      1'b0, 5'd2, 5'd2, 5'd1, 1'b1, 1'b0, 5'b11000};
        tbl[1] = '{"lw_add_rs",      1'b1, 5'd2, 5'd2, 5'd1, 1'b1, 1'b0, 5'b00010};
        tbl[2] = '{"after_bubble",   1'b0, 5'd0, 5'd2, 5'd1, 1'b1, 1'b0, 5'b11000};
        tbl[3] = '{"lw_rt_used",     1'b1, 5'd2, 5'd5, 5'd2, 1'b1, 1'b0, 5'b00010};
        tbl[4] = '{"lw_rt_unused",   1'b1, 5'd2, 5'd5, 5'd2, 1'b0, 1'b0, 5'b11000};
        tbl[5] = '{"lw_zero_reg",    1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'b11000};
        tbl[6] = '{"branch_over_lu", 1'b1, 5'd2, 5'd2, 5'd1, 1'b1, 1'b1, 5'b11111};
        tbl[7] = '{"branch_only",    1'b0, 5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 5'b11111};

        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(ov), 32'd0);
        chk("reset_addr", 32'(dbg_rd_addr), 32'd0);
        chk("reset_count", cycle_count, 32'd0);
        tick();
        reset = 1'b1;

        // Hazard table in free-run.
        run_req = 1'b1;
        chk_cyc("idle_before_run", 12'h000);
        run_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ex_MemRead = tbl[i].mr; ex_rt = tbl[i].ert; id_rs = tbl[i].rs;
            id_rt = tbl[i].rt; id_uses_rt = tbl[i].ur; mem_pc_src = tbl[i].br;
            @(negedge clk);
            chk(tbl[i].name, 32'(ov[11:7]), 32'(tbl[i].exp));
            tick();
        end
        clear_inputs();
        stop_req = 1'b1;
        @(negedge clk);
        chk("count_after_table", cycle_count, 32'd8);
        chk("stop_cycle_advances", 32'(ov), 32'h0C60);
        tick();
        stop_req = 1'b0;
        @(negedge clk);
        chk("stopped_frozen", 32'(ov), 32'd0);
        chk("count_after_stop", cycle_count, 32'd9);
        tick();

        // Reset during a dump at address 10.
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("dump_addr10", 32'(dbg_rd_addr), 32'd10);
        chk("dump_valid10", 32'(ov), 32'h018);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(ov), 32'd0);
        chk("async_reset_addr", 32'(dbg_rd_addr), 32'd0);
        chk("async_reset_count", cycle_count, 32'd0);
        tick();
        reset = 1'b1;
        chk_cyc("idle_after_reset", 12'h000);

        // Three single steps from IDLE.
        sd_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            chk_cyc("step_frozen_before", 12'h000);
            step_req = 1'b0;
            @(negedge clk);
            chk("step_advance", 32'(ov), 32'h0C62);
            sd_cnt += int'(step_done);
            tick();
        end
        @(negedge clk);
        chk("step_frozen_after", 32'(ov), 32'd0);
        chk("step_count", cycle_count, 32'd3);
        chk("step_pulses", 32'(sd_cnt), 32'd3);
        tick();

        // Run into HALT, drain, then dump from HALTED.
        do_reset();
        run_req = 1'b1;
        chk_cyc("halt_idle", 12'h000);
        run_req = 1'b0;
        chk_cyc("halt_run0", 12'hC60);
        chk_cyc("halt_run1", 12'hC60);
        id_opcode = HALT_OP_DEF;
        chk_cyc("halt_detect_cycle", 12'hC60);
        id_opcode = NOP_OP;
        stop_req = 1'b1;
        for (int d = 0; d < 3; d++) chk_cyc("drain_cycle", 12'h260);
        stop_req = 1'b0;
        chk_cyc("halted_state", 12'h001);
        run_req = 1'b1;
        chk_cyc("halted_run_req", 12'h001);
        run_req = 1'b0;
        @(negedge clk);
        chk("run_ignored", 32'(ov), 32'h001);
        chk("halt_count", cycle_count, 32'd3);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            chk("dump_valid", 32'(ov), 32'h019);
            chk("dump_addr", 32'(dbg_rd_addr), 32'(a));
            tick();
        end
        chk_cyc("dump_done", 12'h005);
        chk_cyc("back_to_halted", 12'h001);

        // Randomized run against the reference model, with periodic resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) begin
                do_reset();
            end else begin
                run_req    = ($urandom_range(0, 15) == 0);
                step_req   = ($urandom_range(0, 15) == 0);
                stop_req   = ($urandom_range(0, 23) == 0);
                dump_req   = ($urandom_range(0, 47) == 0);
                id_opcode  = ($urandom_range(0, 24) == 0) ? HALT_OP_DEF : 6'($urandom_range(0, 62));
                id_rs      = 5'($urandom_range(0, 3));
                id_rt      = 5'($urandom_range(0, 3));
                ex_rt      = 5'($urandom_range(0, 3));
                id_uses_rt = 1'($urandom_range(0, 1));
                ex_MemRead = 1'($urandom_range(0, 1));
                mem_pc_src = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                model_outputs();
                chk("rand_ctl", 32'(ov), 32'(e_out));
                chk("rand_addr", 32'(dbg_rd_addr), 32'(e_addr));
                chk("rand_count", cycle_count, m_count);
                model_advance();
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
